bf16_mul_pipe: RTL and testbench

- Pipelined bf16 × bf16 multiplier.
- Sits directly downstream of the bf16 classifier (`bf16_class`): it consumes that classifier's flags `{nan, zero, inf, norm}` and its sign/exp/sig fields for both operands.
- Produces a rounded bf16 product through a valid/ready stream interface with full backpressure.
- First arithmetic stage of the KAN datapath; feeds the accumulator.

---
 rtl/bf16_pkg.sv | 27 ++
 rtl/bf16_class.sv | 28 ++
 rtl/bf16_mul_round.sv | 61 ++++++
 rtl/bf16_mul_pipe.sv | 141 ++++++++++++++
 tb/tb_bf16_mul_pipe.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bf16_pkg.sv
// Shared constants and types for the bf16 multiply pipeline.
// Exception bit indices are only meaningful when BF16_MUL_EXC_EN is defined.
package bf16_pkg;

    localparam int unsigned NUM_W  = 16;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned SIG_W  = 7;
    localparam int unsigned FLAG_W = 4;
    // Exponent sum needs two extra bits: one for sign, one for headroom.
    localparam int unsigned EXT_W  = EXP_W + 2;

    localparam int unsigned BIAS = 127;
    localparam logic [NUM_W-1:0] QNAN = 16'h7FC0;

    localparam int unsigned FLG_NAN  = 3;
    localparam int unsigned FLG_ZERO = 2;
    localparam int unsigned FLG_INF  = 1;
    localparam int unsigned FLG_NORM = 0;

    localparam int unsigned EXC_INVALID   = 3;
    localparam int unsigned EXC_OVERFLOW  = 2;
    localparam int unsigned EXC_UNDERFLOW = 1;
    localparam int unsigned EXC_INEXACT   = 0;

    typedef enum logic [1:0] {SpNone, SpNan, SpInf, SpZero} special_e;

endpackage

// File: rtl/bf16_class.sv
// bf16 classifier: splits a bf16 word into fields and one-hot {nan, zero, inf, norm}.
// Subnormals (exp=0, sig!=0) are reported as norm; consumers decide whether to flush.
module bf16_class
    import bf16_pkg::*;
(
    input  logic [NUM_W-1:0]  num,
    output logic              sign,
    output logic [EXP_W-1:0]  exp,
    output logic [SIG_W-1:0]  sig,
    output logic [FLAG_W-1:0] flags
);

    always_comb begin
        sign  = num[NUM_W-1];
        exp   = num[NUM_W-2:SIG_W];
        sig   = num[SIG_W-1:0];
        flags = '0;
        if (exp == '1) begin
            if (sig != '0) flags[FLG_NAN] = 1'b1;
            else           flags[FLG_INF] = 1'b1;
        end else if (exp == '0 && sig == '0) begin
            flags[FLG_ZERO] = 1'b1;
        end else begin
            flags[FLG_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/bf16_mul_round.sv
// Normalize, round-to-nearest-even and pack a raw 8x8 significand product.
// Exception outputs exist only when BF16_MUL_EXC_EN is defined.
module bf16_mul_round
    import bf16_pkg::*;
(
    input  logic                    sign,
    input  logic signed [EXT_W-1:0] exp,
    input  logic [2*SIG_W+1:0]      prod,
    output logic [NUM_W-1:0]        result
`ifdef BF16_MUL_EXC_EN
    ,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
`endif
);

    localparam logic signed [EXT_W-1:0] E_ONE = EXT_W'(1);
    localparam logic signed [EXT_W-1:0] E_MAX = EXT_W'(255);
    localparam logic signed [EXT_W-1:0] E_MIN = EXT_W'(0);

    logic signed [EXT_W-1:0] e_norm;
    logic signed [EXT_W-1:0] e_fin;
    logic [SIG_W-1:0]        mant;
    logic [SIG_W:0]          mant_inc;
    logic                    guard;
    logic                    sticky;
    logic                    rnd_up;
    logic                    ovf;
    logic                    unf;

    always_comb begin
        // Product of two [1,2) values lies in [1,4); the top bit selects the shift.
        if (prod[2*SIG_W+1]) begin
            e_norm = exp + E_ONE;
            mant   = prod[2*SIG_W:SIG_W+1];
            guard  = prod[SIG_W];
            sticky = |prod[SIG_W-1:0];
        end else begin
            e_norm = exp;
            mant   = prod[2*SIG_W-1:SIG_W];
            guard  = prod[SIG_W-1];
            sticky = |prod[SIG_W-2:0];
        end
        rnd_up   = guard & (sticky | mant[0]);
        mant_inc = {1'b0, mant} + {{SIG_W{1'b0}}, rnd_up};
        e_fin    = mant_inc[SIG_W] ? e_norm + E_ONE : e_norm;
        ovf      = (e_fin >= E_MAX);
        unf      = (e_fin <= E_MIN);
        if (ovf)      result = {sign, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
        else if (unf) result = {sign, {(NUM_W-1){1'b0}}};
        else          result = {sign, e_fin[EXP_W-1:0], mant_inc[SIG_W-1:0]};
    end

`ifdef BF16_MUL_EXC_EN
    assign overflow  = ovf;
    assign underflow = unf;
    assign inexact   = guard | sticky | ovf | unf;
`endif

endmodule

// File: rtl/bf16_mul_pipe.sv
// Three-stage bf16 x bf16 multiplier with valid/ready backpressure (FTZ, RNE).
// Define BF16_MUL_EXC_EN to add the o_exc {invalid, overflow, underflow, inexact} port.
module bf16_mul_pipe
    import bf16_pkg::*;
#(
    parameter int unsigned NUM_WIDTH  = NUM_W,
    parameter int unsigned EXP_WIDTH  = EXP_W,
    parameter int unsigned SIG_WIDTH  = SIG_W,
    parameter int unsigned FLAG_WIDTH = FLAG_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_WIDTH-1:0] i_a,
    input  logic [NUM_WIDTH-1:0] i_b,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [NUM_WIDTH-1:0] o_result,
    output logic                 o_valid,
    input  logic                 i_ready
`ifdef BF16_MUL_EXC_EN
    ,
    output logic [3:0]           o_exc
`endif
);

    logic                  sign_a, sign_b;
    logic [EXP_WIDTH-1:0]  exp_a, exp_b;
    logic [SIG_WIDTH-1:0]  sig_a, sig_b;
    logic [FLAG_WIDTH-1:0] flg_a, flg_b;
    logic                  zero_a, zero_b;
    logic                  advance;

    // Stage registers
    logic                    v1, v2, v3;
    logic                    s1_sign, s1_nan, s1_inf, s1_zero;
    logic [EXP_WIDTH-1:0]    s1_exp_a, s1_exp_b;
    logic [SIG_WIDTH-1:0]    s1_sig_a, s1_sig_b;
    logic                    s2_sign;
    special_e                s2_special;
    logic signed [EXT_W-1:0] s2_exp;
    logic [2*SIG_WIDTH+1:0]  s2_prod;
    logic [NUM_WIDTH-1:0]    res_q;

    special_e                special_d;
    logic signed [EXT_W-1:0] exp_d;
    logic [2*SIG_WIDTH+1:0]  prod_d;
    logic [NUM_WIDTH-1:0]    rnd_result;
    logic [NUM_WIDTH-1:0]    res_d;

    bf16_class u_class_a (.num(i_a), .sign(sign_a), .exp(exp_a), .sig(sig_a), .flags(flg_a));
    bf16_class u_class_b (.num(i_b), .sign(sign_b), .exp(exp_b), .sig(sig_b), .flags(flg_b));

    // Subnormals arrive flagged as norm; flush them to zero here.
    assign zero_a  = flg_a[FLG_ZERO] | (flg_a[FLG_NORM] & (exp_a == '0));
    assign zero_b  = flg_b[FLG_ZERO] | (flg_b[FLG_NORM] & (exp_b == '0));
    assign advance = ~(v3 & ~i_ready);
    assign o_ready = advance;
    assign o_valid = v3;
    assign o_result = res_q;

    always_comb begin
        prod_d = {{(SIG_WIDTH+1){1'b0}}, 1'b1, s1_sig_a}
               * {{(SIG_WIDTH+1){1'b0}}, 1'b1, s1_sig_b};
        exp_d  = EXT_W'(s1_exp_a) + EXT_W'(s1_exp_b) - EXT_W'(BIAS);
        if (s1_nan || (s1_inf && s1_zero)) special_d = SpNan;
        else if (s1_inf)                   special_d = SpInf;
        else if (s1_zero)                  special_d = SpZero;
        else                               special_d = SpNone;
    end

`ifdef BF16_MUL_EXC_EN
    logic       ovf, unf, inx;
    logic [3:0] exc_d, exc_q;

    bf16_mul_round u_round (
        .sign(s2_sign), .exp(s2_exp), .prod(s2_prod), .result(rnd_result),
        .overflow(ovf), .underflow(unf), .inexact(inx)
    );

    always_comb begin
        exc_d = '0;
        unique case (s2_special)
            SpNan:   exc_d[EXC_INVALID] = 1'b1;
            SpNone:  begin
                exc_d[EXC_OVERFLOW]  = ovf;
                exc_d[EXC_UNDERFLOW] = unf;
                exc_d[EXC_INEXACT]   = inx;
            end
            default: exc_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     exc_q <= '0;
        else if (advance) exc_q <= exc_d;
    end

    assign o_exc = exc_q;
`else
    bf16_mul_round u_round (
        .sign(s2_sign), .exp(s2_exp), .prod(s2_prod), .result(rnd_result)
    );
`endif

    always_comb begin
        unique case (s2_special)
            SpNan:   res_d = QNAN;
            SpInf:   res_d = {s2_sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
            SpZero:  res_d = {s2_sign, {(NUM_WIDTH-1){1'b0}}};
            default: res_d = rnd_result;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            s1_sign <= 1'b0; s1_nan <= 1'b0; s1_inf <= 1'b0; s1_zero <= 1'b0;
            s1_exp_a <= '0; s1_exp_b <= '0; s1_sig_a <= '0; s1_sig_b <= '0;
            s2_sign <= 1'b0; s2_special <= SpNone; s2_exp <= '0; s2_prod <= '0;
            res_q <= '0;
        end else if (advance) begin
            v1 <= i_valid;
            v2 <= v1;
            v3 <= v2;
            s1_sign  <= sign_a ^ sign_b;
            s1_nan   <= flg_a[FLG_NAN] | flg_b[FLG_NAN];
            s1_inf   <= flg_a[FLG_INF] | flg_b[FLG_INF];
            s1_zero  <= zero_a | zero_b;
            s1_exp_a <= exp_a;
            s1_exp_b <= exp_b;
            s1_sig_a <= sig_a;
            s1_sig_b <= sig_b;
            s2_sign    <= s1_sign;
            s2_special <= special_d;
            s2_exp     <= exp_d;
            s2_prod    <= prod_d;
            res_q <= res_d;
        end
    end

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// Scoreboard bench for bf16_mul_pipe: directed corners, stall, reset and random traffic.
module tb_bf16_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] a = '0, b = '0;
    logic        in_valid = 1'b0;
    logic        rdy_o;
    logic [15:0] res;
    logic        out_valid;
    logic        ds_ready = 1'b1;
`ifdef BF16_MUL_EXC_EN
    logic [3:0]  exc;
`endif

    bf16_mul_pipe dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_valid(in_valid),
        .o_ready(rdy_o), .o_result(res), .o_valid(out_valid), .i_ready(ds_ready)
`ifdef BF16_MUL_EXC_EN
        , .o_exc(exc)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  exc;
        int          issue;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: exact integer product, RNE decided by comparing the discarded remainder.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
        exp_t r;
        int ea, eb, ma, mb, p, sh, q, rem, half, e;
        bit s, na, nb, ia, ib, za, zb, inexact;
        logic [31:0] ev, qv;
        ea = int'(x[14:7]); eb = int'(y[14:7]);
        ma = int'(x[6:0]);  mb = int'(y[6:0]);
        s  = x[15] ^ y[15];
        na = (ea == 255) && (ma != 0); nb = (eb == 255) && (mb != 0);
        ia = (ea == 255) && (ma == 0); ib = (eb == 255) && (mb == 0);
        za = (ea == 0);                zb = (eb == 0);
        r.exc = 4'h0; r.issue = 0; r.lat = 1'b0;
        if (na || nb || (ia && zb) || (ib && za)) begin
            r.res = 16'h7FC0; r.exc = 4'b1000; return r;
        end
        if (ia || ib) begin r.res = {s, 8'hFF, 7'h00}; return r; end
        if (za || zb) begin r.res = {s, 15'h0000}; return r; end
        p = (128 + ma) * (128 + mb);
        e = ea + eb - 127;
        if (p >= 32768) begin sh = 8; e = e + 1; end
        else sh = 7;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 1 << (sh - 1);
        inexact = (rem != 0);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q == 256) begin q = 128; e = e + 1; end
        ev = e; qv = q;
        if (e >= 255) begin
            r.res = {s, 8'hFF, 7'h00}; r.exc = 4'b0101;
        end else if (e <= 0) begin
            r.res = {s, 15'h0000}; r.exc = 4'b0011;
        end else begin
            r.res = {s, ev[7:0], qv[6:0]}; r.exc = {3'b000, inexact};
        end
        return r;
    endfunction

    // Monitor: pops on every output handshake, checks hold-while-stalled and o_ready.
    bit          stall_prev = 1'b0;
    logic [15:0] hold_res;
    logic [3:0]  hold_exc;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            chk("o_ready", {15'h0, rdy_o}, {15'h0, !(out_valid && !ds_ready)});
            if (stall_prev && out_valid) begin
                chk("hold_result", res, hold_res);
`ifdef BF16_MUL_EXC_EN
                chk("hold_exc", {12'h0, exc}, {12'h0, hold_exc});
`endif
            end
            if (out_valid && ds_ready) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output actual=%h required=none", res);
                end else begin
                    e = sb.pop_front();
                    chk("result", res, e.res);
`ifdef BF16_MUL_EXC_EN
                    chk("exc", {12'h0, exc}, {12'h0, e.exc});
`endif
                    if (e.lat) chk("latency", 16'(cyc - e.issue), 16'd3);
                end
            end
            stall_prev = out_valid && !ds_ready;
            hold_res   = res;
`ifdef BF16_MUL_EXC_EN
            hold_exc   = exc;
`else
            hold_exc   = 4'h0;
`endif
        end
    end

    task automatic issue(input logic [15:0] x, input logic [15:0] y, input bit lat);
        exp_t e;
        int   n;
        a = x; b = y; in_valid = 1'b1;
        e = model(x, y); e.lat = lat;
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy_o) begin
                e.issue = cyc;
                sb.push_back(e);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                checks++; failures++;
                $display("FAIL issue_timeout actual=stalled required=ready");
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk); n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d_pending required=0", sb.size());
        end
    endtask

    function automatic logic [15:0] rnd_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 7))
            0: ;
            1: v[14:7] = 8'hFF;
            2: v[14:7] = 8'h00;
            3: v[14:7] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 10))
                                                     : 8'($urandom_range(245, 254));
            default: v[14:7] = 8'($urandom_range(90, 165));
        endcase
        return v;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_o_valid", {15'h0, out_valid}, 16'h0);
        chk("reset_o_result", res, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_o_ready", {15'h0, rdy_o}, 16'h1);
        @(posedge clk); #1;

        // Directed corners, one at a time so latency is exact.
        issue(16'h3F80, 16'h3F80, 1'b1); drain();
        issue(16'h3FC0, 16'h3FC0, 1'b1); drain();
        issue(16'h3F81, 16'h3F81, 1'b0);
        issue(16'h7F80, 16'h0000, 1'b0);
        issue(16'hFF80, 16'h3F80, 1'b0);
        issue(16'h0001, 16'h3F80, 1'b0);
        issue(16'h7F00, 16'h7F00, 1'b0);
        issue(16'h0080, 16'h0080, 1'b0);
        issue(16'h7FC1, 16'h0000, 1'b0);
        issue(16'hBF80, 16'h4000, 1'b0);
        drain();

        // Six back-to-back products with a two-cycle downstream stall.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    issue({1'b0, 8'($urandom_range(110, 140)), 7'($urandom)}, 16'h3FA0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 ds_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1 ds_ready = 1'b1;
            end
        join
        drain();

        // Reset with three products in flight.
        issue(16'h3F80, 16'h4040, 1'b0);
        issue(16'h4000, 16'h4000, 1'b0);
        issue(16'h3FC0, 16'h4080, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_o_valid", {15'h0, out_valid}, 16'h0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        issue(16'h4040, 16'h4040, 1'b1);
        drain();

        // Random traffic with random gaps and random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    issue(rnd_op(), rnd_op(), 1'b0);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    ds_ready = ($urandom_range(0, 3) != 0);
                end
                ds_ready = 1'b1;
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
